wb_regfile_sb: RTL
==================

Name: wb_regfile_sb

Overview:
- Consumer end of the writeback-to-decode interface: the ID-side integer register file plus a per-register pending-write scoreboard.
- Accepts the registered writeback triple (rd, result, regwrite) and commits it to the architectural registers.
- Serves two combinational read ports to decode, with same-cycle write-through bypass.
- Tracks in-flight writers issued from ID, so decode can stall on RAW hazards it cannot forward.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- CNT_W, 2, width of each per-register pending-writer counter.

Ports:
- clk  in  1  core clock
- Rst  in  1  asynchronous active-high reset
- wb_rd  in  5  writeback destination register
- wb_res  in  32  writeback result
- wb_regwrite  in  1  writeback commit strobe
- wb_fpusrc  in  1  writeback targets FP bank (used only with the macro)
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_fp, rs2_fp  in  1 each  read from FP bank (used only with the macro)
- rs1_data, rs2_data  out  32 each  read data
- issue_valid  in  1  decode issues an instruction this cycle
- issue_rd  in  5  destination of the issued instruction
- issue_regwrite  in  1  issued instruction will write back
- issue_fp  in  1  issued destination is FP (used only with the macro)
- sb_clr  in  1  synchronous clear of all counters; asserted only when the pipeline is drained
- rs1_busy, rs2_busy  out  1 each  source register has an unretired writer
- issue_stall  out  1  issue_rd counter is saturated
- sb_underflow  out  1  sticky error flag

Behaviour:
- Reset (async, Rst=1): all registers, all counters and sb_underflow go to 0. rs*_data then read 0; busy and stall outputs read 0.
- Write: on posedge clk, if wb_regwrite && wb_rd!=0, write reg[wb_rd] <= wb_res. Writes to x0 are dropped.
- Read: combinational, 0-cycle latency. Address 0 returns 0.
- Bypass: if wb_regwrite && wb_rd==rsN_addr && rsN_addr!=0 in the same cycle, rsN_data = wb_res.
- Scoreboard, inc: counter[issue_rd]++ when issue_valid && issue_regwrite && issue_rd!=0 && !issue_stall.
- Scoreboard, dec: counter[wb_rd]-- when wb_regwrite && wb_rd!=0.
- Simultaneous inc and dec of the same register: counter unchanged.
- Dec at 0: counter held at 0, and sb_underflow is set. It stays set until reset.
- Saturation: issue_stall = issue_valid && issue_regwrite && issue_rd!=0 && counter[issue_rd]=={CNT_W{1}}. When issue_stall=1 there is no increment; decode must hold the instruction.
- Busy: rsN_busy = counter[rsN]!=0 && !(counter[rsN]==1 && wb_regwrite && wb_rd==rsN). This lets the retiring value be taken via bypass in the same cycle. rsN==0 is never busy.
- sb_clr has priority over inc/dec and zeroes every counter next cycle. Register contents are untouched.
- Reset asserted mid-operation: immediate clear of everything; in-flight state is lost by design.

Optional Feature:
- Macro: WB_REGFILE_FP_BANK_EN.
- When defined:
  - A second NREG x 32 FP bank with its own counters is instantiated.
  - wb_fpusrc selects the bank for write and dec; issue_fp selects the bank for inc.
  - rs1_fp/rs2_fp select the bank for read, bypass and busy.
  - f0 is a real, writable register with no zero hardwiring.
  - Bypass and busy matching require both the bank and the address to match.
- When undefined: the FP inputs are ignored, there is only an integer bank, and area is as the base design.

Decomposition:
- Shared package wb_regfile_pkg:
  - REG_ADDR_W=5, XLEN=32.
  - typedef reg_addr_t and typedef sb_cnt_t (logic [CNT_W-1:0]).
  - Function sb_next(cnt, inc, dec) returning the next count and an underflow bit.
- One sub-module, wb_regfile_bank: storage, read/bypass and counters for one bank. Instantiated once, or twice under the macro.

Test Plan:
- Reset, then write wb_rd=5, wb_res=32'hDEADBEEF -> rs1_addr=5 reads 32'hDEADBEEF the next cycle; rs2_addr=0 reads 0.
- Same-cycle wb_rd=7, wb_res=32'h12345678 with rs1_addr=7 -> rs1_data=32'h12345678 combinationally, before the clock edge.
- Issue rd=3 three times, then a fourth issue -> counter=3, fourth asserts issue_stall=1 with no increment. After one writeback to x3, the re-issue succeeds.
- Counter[9]=1, writeback to x9 while rs1_addr=9 -> rs1_busy=0 in that cycle and rs1_data=wb_res.
- Writeback to x4 with counter[4]=0 -> sb_underflow=1 and remains 1; Rst pulse clears it. Issue to rd=0 -> no counter change, no stall.
- With WB_REGFILE_FP_BANK_EN: write wb_fpusrc=1, rd=0, res=32'h3F800000 -> FP read of f0 returns 32'h3F800000; integer read of x0 returns 0. Integer write to x2 does not set busy on FP f2.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared types and helpers for the writeback-side register file and its
// pending-write scoreboard.
package wb_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

    // Next count plus an underflow indication. The count is carried at a
    // fixed 32-bit width so banks with any counter width can share it.
    typedef struct packed {
        logic [31:0] cnt;
        logic        uf;
    } sb_next_t;

    // Simultaneous inc/dec cancel out; a dec of an empty counter holds it at
    // zero and reports underflow. Saturation is prevented upstream by the
    // issue stall, so inc never wraps here.
    function automatic sb_next_t sb_next(input logic [31:0] cnt,
                                         input logic        inc,
                                         input logic        dec);
        sb_next_t r;
        r.cnt = cnt;
        r.uf  = 1'b0;
        if (inc && !dec) begin
            r.cnt = cnt + 32'd1;
        end else if (dec && !inc) begin
            if (cnt == 32'd0) begin
                r.uf = 1'b1;
            end else begin
                r.cnt = cnt - 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_regfile_bank.sv
// One register bank: storage, two combinational read ports with write-through
// bypass, and per-register pending-writer counters.
// HARD_ZERO=1 makes entry 0 a constant-zero register that never counts.
module wb_regfile_bank
    import wb_regfile_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int CNT_W     = SB_CNT_W,
    parameter bit HARD_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  reg_addr_t       wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic            rd1_en_i,
    input  reg_addr_t       rd1_addr_i,
    output logic [XLEN-1:0] rd1_data_o,
    output logic            rd1_busy_o,
    input  logic            rd2_en_i,
    input  reg_addr_t       rd2_addr_i,
    output logic [XLEN-1:0] rd2_data_o,
    output logic            rd2_busy_o,
    input  logic            inc_en_i,
    input  reg_addr_t       inc_addr_i,
    output logic            inc_stall_o,
    input  logic            clr_i,
    output logic            uf_o
);

    logic [XLEN-1:0]  mem_q [NREG];
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    sb_next_t         nx;
    logic             wr_act;
    logic             inc_req;
    logic             inc_act;

    // Entry 0 is only a real register when the bank is not zero-hardwired.
    function automatic logic live(input reg_addr_t a);
        return !HARD_ZERO || (a != '0);
    endfunction

    // Effective write/dec and inc strobes after zero-register filtering.
    always_comb begin
        wr_act      = wr_en_i && live(wr_addr_i);
        inc_req     = inc_en_i && live(inc_addr_i);
        inc_stall_o = inc_req && (cnt_q[inc_addr_i] == {CNT_W{1'b1}});
        inc_act     = inc_req && !inc_stall_o;
    end

    // Read ports: a committing writeback to the same entry is forwarded.
    always_comb begin
        rd1_data_o = '0;
        rd2_data_o = '0;
        if (rd1_en_i && live(rd1_addr_i)) begin
            rd1_data_o = (wr_act && (wr_addr_i == rd1_addr_i)) ? wr_data_i : mem_q[rd1_addr_i];
        end
        if (rd2_en_i && live(rd2_addr_i)) begin
            rd2_data_o = (wr_act && (wr_addr_i == rd2_addr_i)) ? wr_data_i : mem_q[rd2_addr_i];
        end
    end

    // Busy unless the last outstanding writer retires now (taken via bypass).
    always_comb begin
        rd1_busy_o = rd1_en_i && live(rd1_addr_i) && (cnt_q[rd1_addr_i] != '0) &&
                     !((cnt_q[rd1_addr_i] == CNT_W'(1)) && wr_act && (wr_addr_i == rd1_addr_i));
        rd2_busy_o = rd2_en_i && live(rd2_addr_i) && (cnt_q[rd2_addr_i] != '0) &&
                     !((cnt_q[rd2_addr_i] == CNT_W'(1)) && wr_act && (wr_addr_i == rd2_addr_i));
    end

    // Counter next state; a clear overrides any inc/dec in the same cycle.
    always_comb begin
        nx   = '0;
        uf_o = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            nx = sb_next(32'(cnt_q[i]),
                         inc_act && (inc_addr_i == REG_ADDR_W'(i)),
                         wr_act  && (wr_addr_i  == REG_ADDR_W'(i)));
            cnt_d[i] = CNT_W'(nx.cnt);
            if (nx.uf) begin
                uf_o = 1'b1;
            end
            if (clr_i) begin
                cnt_d[i] = '0;
            end
        end
        if (clr_i) begin
            uf_o = 1'b0;
        end
    end

    // Architectural storage; reset wipes every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_act) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Pending-writer counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/wb_regfile_sb.sv
// ID-side register file with pending-write scoreboard, fed by the registered
// writeback triple. Optional FP bank enabled by macro WB_REGFILE_FP_BANK_EN;
// without it the FP select inputs are ignored.
module wb_regfile_sb
    import wb_regfile_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic            clk,
    input  logic            Rst,
    input  reg_addr_t       wb_rd,
    input  logic [XLEN-1:0] wb_res,
    input  logic            wb_regwrite,
    input  logic            wb_fpusrc,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    input  logic            rs1_fp,
    input  logic            rs2_fp,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  reg_addr_t       issue_rd,
    input  logic            issue_regwrite,
    input  logic            issue_fp,
    input  logic            sb_clr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            issue_stall,
    output logic            sb_underflow
);

    logic            issue_req;
    logic            int_wr, int_rd1, int_rd2, int_inc;
    logic [XLEN-1:0] int_rd1_data, int_rd2_data;
    logic            int_rd1_busy, int_rd2_busy, int_stall, int_uf;
    logic [XLEN-1:0] fp_rd1_data, fp_rd2_data;
    logic            fp_rd1_busy, fp_rd2_busy, fp_stall, fp_uf;
    logic            sb_underflow_q;

    assign issue_req = issue_valid && issue_regwrite;

    wb_regfile_bank #(
        .NREG      (NREG),
        .CNT_W     (CNT_W),
        .HARD_ZERO (1'b1)
    ) u_int_bank (
        .clk         (clk),
        .rst         (Rst),
        .wr_en_i     (int_wr),
        .wr_addr_i   (wb_rd),
        .wr_data_i   (wb_res),
        .rd1_en_i    (int_rd1),
        .rd1_addr_i  (rs1_addr),
        .rd1_data_o  (int_rd1_data),
        .rd1_busy_o  (int_rd1_busy),
        .rd2_en_i    (int_rd2),
        .rd2_addr_i  (rs2_addr),
        .rd2_data_o  (int_rd2_data),
        .rd2_busy_o  (int_rd2_busy),
        .inc_en_i    (int_inc),
        .inc_addr_i  (issue_rd),
        .inc_stall_o (int_stall),
        .clr_i       (sb_clr),
        .uf_o        (int_uf)
    );

`ifdef WB_REGFILE_FP_BANK_EN
    assign int_wr  = wb_regwrite && !wb_fpusrc;
    assign int_rd1 = !rs1_fp;
    assign int_rd2 = !rs2_fp;
    assign int_inc = issue_req && !issue_fp;

    // FP bank: f0 is an ordinary register.
    wb_regfile_bank #(
        .NREG      (NREG),
        .CNT_W     (CNT_W),
        .HARD_ZERO (1'b0)
    ) u_fp_bank (
        .clk         (clk),
        .rst         (Rst),
        .wr_en_i     (wb_regwrite && wb_fpusrc),
        .wr_addr_i   (wb_rd),
        .wr_data_i   (wb_res),
        .rd1_en_i    (rs1_fp),
        .rd1_addr_i  (rs1_addr),
        .rd1_data_o  (fp_rd1_data),
        .rd1_busy_o  (fp_rd1_busy),
        .rd2_en_i    (rs2_fp),
        .rd2_addr_i  (rs2_addr),
        .rd2_data_o  (fp_rd2_data),
        .rd2_busy_o  (fp_rd2_busy),
        .inc_en_i    (issue_req && issue_fp),
        .inc_addr_i  (issue_rd),
        .inc_stall_o (fp_stall),
        .clr_i       (sb_clr),
        .uf_o        (fp_uf)
    );
`else
    logic unused_fp_sel;

    assign int_wr        = wb_regwrite;
    assign int_rd1       = 1'b1;
    assign int_rd2       = 1'b1;
    assign int_inc       = issue_req;
    assign fp_rd1_data   = '0;
    assign fp_rd2_data   = '0;
    assign fp_rd1_busy   = 1'b0;
    assign fp_rd2_busy   = 1'b0;
    assign fp_stall      = 1'b0;
    assign fp_uf         = 1'b0;
    assign unused_fp_sel = ^{wb_fpusrc, rs1_fp, rs2_fp, issue_fp};
`endif

    // Each bank drives zero on ports it does not own, so OR merges them.
    assign rs1_data     = int_rd1_data | fp_rd1_data;
    assign rs2_data     = int_rd2_data | fp_rd2_data;
    assign rs1_busy     = int_rd1_busy | fp_rd1_busy;
    assign rs2_busy     = int_rd2_busy | fp_rd2_busy;
    assign issue_stall  = int_stall | fp_stall;
    assign sb_underflow = sb_underflow_q;

    // Sticky underflow flag; only reset clears it.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sb_underflow_q <= 1'b0;
        end else if (int_uf || fp_uf) begin
            sb_underflow_q <= 1'b1;
        end
    end

endmodule
